// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator sharing one prescaled timebase
//
// One counter drives CHANNELS comparators. Duty values are written into shadow
// registers at any time and only become active at a period boundary, so a
// running period is never disturbed. Edge-aligned mode counts 0..P; center
// mode counts up to P and back down to 1.

module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 8,
  parameter int PRE_BITS = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                center,
  input  logic [PRE_BITS-1:0] prescale,
  input  logic [BITS-1:0]     period,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [BITS-1:0]     wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Timebase state
  logic [PRE_BITS-1:0] pre_q, pre_d;
  logic                tick;
  logic [BITS-1:0]     cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic                boundary;

  // Shadow and active configuration
  logic [BITS-1:0]     duty_sh_q [CHANNELS];
  logic [BITS-1:0]     duty_sh_d [CHANNELS];
  logic [BITS-1:0]     duty_a_q  [CHANNELS];
  logic [BITS-1:0]     duty_a_d  [CHANNELS];
  logic [BITS-1:0]     per_a_q, per_a_d;
  logic                mode_a_q, mode_a_d;
  logic                load_act;

  // Registered outputs
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                start_q, start_d;

  assign pwm_out      = pwm_q;
  assign period_start = start_q;

  // Prescaler next state: tick on the last count, then wrap; cleared while idle.
  // Using >= lets a prescale value lowered below the running count wrap at
  // once instead of rolling through the whole register range.
  always_comb begin
    tick  = 1'b0;
    pre_d = pre_q;
    if (!en) begin
      pre_d = '0;
    end else if (pre_q >= prescale) begin
      tick  = 1'b1;
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_BITS'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Counter / direction next state and boundary detection
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (!mode_a_q) begin
        // Edge-aligned: 0..P_a then wrap; P_a=0 makes every tick a boundary
        if (cnt_q >= per_a_q) begin
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + BITS'(1);
        end
      end else begin
        unique case (dir_q)
          DIR_UP: begin
            if (cnt_q < per_a_q) begin
              cnt_d = cnt_q + BITS'(1);
            end else if (per_a_q <= BITS'(1)) begin
              // Too short to turn around: period is just the up-ramp
              boundary = 1'b1;
            end else begin
              cnt_d = per_a_q - BITS'(1);
              dir_d = DIR_DOWN;
            end
          end
          DIR_DOWN: begin
            if (cnt_q > BITS'(1)) begin
              cnt_d = cnt_q - BITS'(1);
            end else begin
              boundary = 1'b1;
            end
          end
          default: boundary = 1'b1;
        endcase
      end
      if (boundary) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end
    end
  end

  // Counter and direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Shadow duty next state; an out-of-range wr_ch matches no channel
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_sh_d[i] = duty_sh_q[i];
      if (wr_en && (wr_ch == CH_W'(i))) begin
        duty_sh_d[i] = wr_duty;
      end
    end
  end

  // Shadow duty registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i] <= duty_sh_d[i];
      end
    end
  end

  // Active configuration next state: copy shadow/inputs at a boundary or while idle.
  // The copy reads duty_sh_q, so a write landing on the boundary edge waits
  // for the following boundary.
  always_comb begin
    load_act = !en || boundary;
    per_a_d  = per_a_q;
    mode_a_d = mode_a_q;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_a_d[i] = duty_a_q[i];
    end
    if (load_act) begin
      per_a_d  = period;
      mode_a_d = center;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_a_d[i] = duty_sh_q[i];
      end
    end
  end

  // Active configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_a_q  <= '0;
      mode_a_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_a_q[i] <= '0;
      end
    end else begin
      per_a_q  <= per_a_d;
      mode_a_q <= mode_a_d;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_a_q[i] <= duty_a_d[i];
      end
    end
  end

  // Output next state: compare the current count against each active duty
  always_comb begin
    pwm_d   = '0;
    start_d = boundary;
    if (en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = (cnt_q < duty_a_q[i]);
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q   <= '0;
      start_q <= 1'b0;
    end else begin
      pwm_q   <= pwm_d;
      start_q <= start_d;
    end
  end

endmodule
